// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes, hold-limit default and FSM state type for rr_arbiter8
package arb_pkg;
  localparam int N = 8;
  localparam int IDXW = 3;
  localparam int MAX_HOLD_DEF = 16;
  localparam int HOLD_W = $clog2(MAX_HOLD_DEF);
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: circular first-set search of req from ptr upward; in req,ptr; out found,idx
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx
);
  logic [N-1:0] w_rot;
  logic [IDXW-1:0] w_enc;
  assign w_rot = N'({req, req} >> ptr);
  always_comb begin
    w_enc = '0;
    for (int i = N - 1; i >= 0; i--)
      if (w_rot[i]) w_enc = i[IDXW-1:0];
  end
  assign found = |req;
  assign idx = w_enc + ptr;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with hold timeout; in clk,rst_n,arb_en,req,done; out gnt,gnt_idx,gnt_vld,timeout
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arb_en,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);
  localparam int HW = $clog2(MAX_HOLD);
  state_t r_state, w_state_nx;
  logic w_found, w_award, w_rel, w_last, r_timeout;
  logic [IDXW-1:0] w_pick, r_idx, r_ptr;
  logic [HW-1:0] r_hold;
  logic [N-1:0] r_gnt;
  rr_pick u_pick (.req(req), .ptr(r_ptr), .found(w_found), .idx(w_pick));
  assign w_last = r_hold == HW'(MAX_HOLD - 1);
  assign w_award = r_state == IDLE && arb_en && w_found;
  assign w_rel = r_state == GRANT && (done || !req[r_idx] || w_last);
  always_comb w_state_nx = w_award ? GRANT : w_rel ? IDLE : r_state;
  always_ff @(posedge clk)
    r_state <= !rst_n ? IDLE : w_state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt <= '0;
      r_idx <= '0;
      r_ptr <= '0;
      r_hold <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_gnt <= w_award ? N'(1) << w_pick : w_rel ? '0 : r_gnt;
      r_idx <= w_award ? w_pick : w_rel ? '0 : r_idx;
      r_ptr <= w_award ? w_pick + 1'b1 : r_ptr;
      r_hold <= r_state == GRANT ? r_hold + 1'b1 : '0;
      r_timeout <= w_rel && w_last;
    end
  end
  assign gnt = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = r_state == GRANT;
  assign timeout = r_timeout;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed plus random checks of rr_arbiter8 against a behavioural ownership model
module tb_rr_arbiter8;
  localparam int MH = 4;
  logic clk = 1'b0, rst_n = 1'b0, arb_en = 1'b0, done = 1'b0;
  logic [7:0] req = '0, gnt;
  logic [2:0] gnt_idx;
  logic gnt_vld, timeout;
  int errors = 0, checks = 0;
  int m_own = -1, m_hold = 0, m_ptr = 0, m_to = 0;
  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic model(input logic r, input logic en, input logic [7:0] rq, input logic dn);
    if (!r) begin
      m_own = -1; m_hold = 0; m_ptr = 0; m_to = 0;
    end else if (m_own < 0) begin
      m_to = 0;
      if (en && rq != 0)
        for (int k = 0; k < 8; k++)
          if (m_own < 0 && rq[(m_ptr + k) % 8]) m_own = (m_ptr + k) % 8;
      if (m_own >= 0) begin
        m_hold = 0;
        m_ptr = (m_own + 1) % 8;
      end
    end else if (dn || !rq[m_own] || m_hold == MH - 1) begin
      m_to = (m_hold == MH - 1) ? 1 : 0;
      m_own = -1;
    end else m_hold++;
  endtask
  task automatic step(input logic r, input logic en, input logic [7:0] rq, input logic dn);
    logic [7:0] e_gnt;
    logic [2:0] e_idx;
    rst_n = r; arb_en = en; req = rq; done = dn;
    @(posedge clk);
    model(r, en, rq, dn);
    e_gnt = m_own < 0 ? 8'h00 : 8'h01 << m_own;
    e_idx = m_own < 0 ? 3'd0 : 3'(m_own);
    #1;
    checks++;
    assert (gnt === e_gnt) else begin errors++; $error("FAIL gnt: got %h expected %h", gnt, e_gnt); end
    checks++;
    assert (gnt_idx === e_idx) else begin errors++; $error("FAIL gnt_idx: got %0d expected %0d", gnt_idx, e_idx); end
    checks++;
    assert (gnt_vld === (m_own >= 0)) else begin errors++; $error("FAIL gnt_vld: got %b expected %b", gnt_vld, m_own >= 0); end
    checks++;
    assert (timeout === (m_to != 0)) else begin errors++; $error("FAIL timeout: got %b expected %b", timeout, m_to != 0); end
  endtask
  initial begin
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'hFF, 0);
    step(1, 1, 8'h81, 0);
    step(1, 1, 8'h81, 1);
    step(1, 1, 8'h81, 0);
    step(1, 1, 8'h81, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 8'hFF, m_own >= 0);
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 14; i++) step(1, 1, 8'h04, 0);
    step(1, 1, 8'h00, 0);
    step(1, 1, 8'h08, 0);
    step(1, 1, 8'h08, 0);
    step(1, 1, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'h3C, 0);
    step(1, 1, 8'h3C, 0);
    step(1, 1, 8'h3C, 1);
    step(1, 1, 8'h20, 0);
    step(1, 1, 8'h20, 0);
    step(1, 1, 8'h20, 0);
    step(0, 1, 8'h20, 0);
    step(1, 1, 8'h21, 0);
    step(1, 1, 8'h21, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 3) == 0 ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom),
           $urandom_range(0, 3) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
